history_mem_arbiter: RTL and testbench

HISTORY_MEM_ARBITER -- requirements
Module: history_mem_arbiter

---
 rtl/history_mem_if.sv | 38 +++
 rtl/history_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_history_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/history_mem_if.sv
// Bundle of the history-memory request/response signals shared by the parser,
// header emitter and register-read requesters.
interface history_mem_if #(
    parameter int unsigned TUPLE_WIDTH = 112,
    parameter int unsigned DEPTH       = 16
) ();
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned BATCH_W = 4 * TUPLE_WIDTH + 64;

    logic                   wr_valid;
    logic [TUPLE_WIDTH-1:0] wr_tuple;
    logic                   wr_ready;
    logic                   batch_req;
    logic [1:0]             batch_idx;
    logic                   batch_gnt;
    logic                   batch_valid;
    logic [BATCH_W-1:0]     batch_data;
    logic                   reg_req;
    logic [PTR_W-1:0]       reg_addr;
    logic                   reg_ack;
    logic [TUPLE_WIDTH-1:0] reg_data;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       wr_count;
    logic                   lock_err;

    modport slave (
        input  wr_valid, wr_tuple, batch_req, batch_idx, reg_req, reg_addr,
        output wr_ready, batch_gnt, batch_valid, batch_data, reg_ack, reg_data,
               wr_ptr, wr_count, lock_err
    );

    modport master (
        output wr_valid, wr_tuple, batch_req, batch_idx, reg_req, reg_addr,
        input  wr_ready, batch_gnt, batch_valid, batch_data, reg_ack, reg_data,
               wr_ptr, wr_count, lock_err
    );
endinterface

// File: rtl/history_mem_arbiter.sv
// 16-entry tuple history with single-grant arbitration between parser writes,
// batch snapshot reads (locked across batches 0..3) and register reads.
module history_mem_arbiter #(
    parameter int unsigned TUPLE_WIDTH  = 112,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input logic            clk,
    input logic            reset,
    history_mem_if.slave   bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned IDLE_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned BATCH_W  = 4 * TUPLE_WIDTH + 64;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic                   lock_err_q, lock_err_d;

    logic [TUPLE_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [CNT_W-1:0]       wr_count_q;
    logic                   batch_valid_q;
    logic [BATCH_W-1:0]     batch_data_q;
    logic                   reg_ack_q;
    logic [TUPLE_WIDTH-1:0] reg_data_q;

    logic                   forced;
    logic                   wr_ready_c;
    logic                   wr_gnt;
    logic                   batch_gnt;
    logic                   reg_gnt;
    logic [BATCH_W-1:0]     batch_word;

    // Arbitration, lock tracking and starvation/idle counters
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        idle_d     = idle_q;
        lock_err_d = lock_err_q;
        forced     = 1'b0;
        wr_ready_c = 1'b0;
        batch_gnt  = 1'b0;
        reg_gnt    = 1'b0;

        case (state_q)
            IDLE: begin
                forced     = bus.reg_req && (starve_q == STARVE_W'(STARVE_LIMIT));
                wr_ready_c = !forced && !bus.batch_req;
                if (forced) begin
                    reg_gnt = 1'b1;
                end else if (bus.batch_req) begin
                    batch_gnt = 1'b1;
                    idle_d    = '0;
                    if (bus.batch_idx == 2'd0) begin
                        state_d = LOCKED;
                    end else begin
                        lock_err_d = 1'b1;
                    end
                end else if (!bus.wr_valid && bus.reg_req) begin
                    reg_gnt = 1'b1;
                end
            end
            LOCKED: begin
                if (bus.batch_req) begin
                    batch_gnt = 1'b1;
                    idle_d    = '0;
                    if (bus.batch_idx == 2'd3) begin
                        state_d = IDLE;
                    end
                end else begin
                    reg_gnt = bus.reg_req;
                    // Abandoned snapshot: give the array back to the writer
                    if (idle_q == IDLE_W'(LOCK_TIMEOUT - 1)) begin
                        lock_err_d = 1'b1;
                        state_d    = IDLE;
                        idle_d     = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reg_gnt) begin
            starve_d = '0;
        end else if (bus.reg_req && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    assign wr_gnt = wr_ready_c && bus.wr_valid;

    // Snapshot word: four entries of the selected batch, first entry in the MSBs
    always_comb begin
        batch_word = '0;
        for (int i = 0; i < 4; i++) begin
            batch_word[BATCH_W-1-i*TUPLE_WIDTH -: TUPLE_WIDTH] = mem[{bus.batch_idx, 2'(i)}];
        end
        batch_word[63 -: PTR_W] = wr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            idle_q     <= '0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            idle_q     <= idle_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Array and read ports; reads see the pre-edge array contents
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q      <= '0;
            wr_count_q    <= '0;
            batch_valid_q <= 1'b0;
            batch_data_q  <= '0;
            reg_ack_q     <= 1'b0;
            reg_data_q    <= '0;
        end else begin
            batch_valid_q <= batch_gnt;
            reg_ack_q     <= reg_gnt;
            if (batch_gnt) begin
                batch_data_q <= batch_word;
            end
            if (reg_gnt) begin
                reg_data_q <= mem[bus.reg_addr];
            end
            if (wr_gnt) begin
                mem[wr_ptr_q] <= bus.wr_tuple;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
                if (wr_count_q != CNT_W'(DEPTH)) begin
                    wr_count_q <= wr_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.wr_ready    = wr_ready_c;
    assign bus.batch_gnt   = batch_gnt;
    assign bus.batch_valid = batch_valid_q;
    assign bus.batch_data  = batch_data_q;
    assign bus.reg_ack     = reg_ack_q;
    assign bus.reg_data    = reg_data_q;
    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.lock_err    = lock_err_q;
endmodule

// File: tb/tb_history_mem_arbiter.sv
// Directed bench for history_mem_arbiter: write wrap, locked batch snapshot,
// register-read starvation, read-before-write, lock timeout and reset abort.
module tb_history_mem_arbiter;
    localparam int unsigned TW = 112;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    history_mem_if #(.TUPLE_WIDTH(TW), .DEPTH(16)) bus ();

    history_mem_arbiter #(
        .TUPLE_WIDTH(TW), .DEPTH(16), .STARVE_LIMIT(4), .LOCK_TIMEOUT(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [TW-1:0] tb_mem [16];
    logic [3:0]    tb_ptr;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr_valid  = 1'b0;
        bus.wr_tuple  = '0;
        bus.batch_req = 1'b0;
        bus.batch_idx = 2'd0;
        bus.reg_req   = 1'b0;
        bus.reg_addr  = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) tb_mem[i] = '0;
        tb_ptr = 4'd0;
    endtask

    // Uncontended write: granted at the next edge
    task automatic write(input logic [TW-1:0] v);
        bus.wr_valid = 1'b1;
        bus.wr_tuple = v;
        tick();
        tb_mem[tb_ptr] = v;
        tb_ptr = tb_ptr + 4'd1;
    endtask

    task automatic reg_read(input string tag, input logic [3:0] addr, input logic [TW-1:0] exp);
        bus.reg_req  = 1'b1;
        bus.reg_addr = addr;
        tick();
        bus.reg_req = 1'b0;
        check({tag, "_ack"}, bus.reg_ack, 1'b1);
        check(tag, bus.reg_data, exp);
    endtask

    function automatic logic [511:0] exp_batch(input int k);
        logic [511:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[511-i*TW -: TW] = tb_mem[4*k+i];
        w[63:60] = tb_ptr;
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          ack_cyc;
        logic        rdy5;
        logic [TW-1:0] got_data;
        logic [3:0]  ptr_at_ack;

        do_reset();
        check("rst_wr_ptr", bus.wr_ptr, 4'd0);
        check("rst_wr_count", bus.wr_count, 5'd0);
        check("rst_lock_err", bus.lock_err, 1'b0);
        check("rst_batch_valid", bus.batch_valid, 1'b0);
        check("rst_batch_data", bus.batch_data, 512'd0);
        check("rst_reg_ack", bus.reg_ack, 1'b0);
        check("rst_wr_ready", bus.wr_ready, 1'b1);

        // 18 writes: pointer wraps, count saturates
        for (int i = 1; i <= 18; i++) begin
            write(TW'(i));
            if (i == 16) begin
                check("wr16_count", bus.wr_count, 5'd16);
                check("wr16_ptr", bus.wr_ptr, 4'd0);
            end
        end
        bus.wr_valid = 1'b0;
        check("wr18_ptr", bus.wr_ptr, 4'd2);
        check("wr18_count", bus.wr_count, 5'd16);
        reg_read("rd_mem0", 4'd0, TW'('h11));
        reg_read("rd_mem1", 4'd1, TW'('h12));
        reg_read("rd_mem2", 4'd2, TW'('h3));

        // Locked snapshot across batches 0..3 with a writer waiting
        bus.wr_valid = 1'b1;
        bus.wr_tuple = TW'('hAA);
        for (int k = 0; k < 4; k++) begin
            bus.batch_req = 1'b1;
            bus.batch_idx = 2'(k);
            settle();
            check($sformatf("lock_wr_ready%0d", k), bus.wr_ready, 1'b0);
            check($sformatf("lock_gnt%0d", k), bus.batch_gnt, 1'b1);
            tick();
            check($sformatf("lock_bvalid%0d", k), bus.batch_valid, 1'b1);
            check($sformatf("lock_bdata%0d", k), bus.batch_data, exp_batch(k));
            check($sformatf("lock_bptr%0d", k), bus.batch_data[63:60], 4'd2);
        end
        bus.batch_req = 1'b0;
        settle();
        check("unlock_wr_ready", bus.wr_ready, 1'b1);
        tick();
        tb_mem[tb_ptr] = TW'('hAA);
        tb_ptr = tb_ptr + 4'd1;
        bus.wr_valid = 1'b0;
        check("unlock_wr_ptr", bus.wr_ptr, 4'd3);
        check("unlock_lock_err", bus.lock_err, 1'b0);

        // Register read starved by batch (idx 1, stays IDLE) and write traffic
        bus.reg_req   = 1'b1;
        bus.reg_addr  = 4'd7;
        bus.batch_req = 1'b1;
        bus.batch_idx = 2'd1;
        bus.wr_valid  = 1'b1;
        bus.wr_tuple  = TW'('hEE);
        ack_cyc = 0;
        for (int c = 1; c <= 12 && ack_cyc == 0; c++) begin
            tick();
            if (bus.reg_ack) ack_cyc = c + 1;
        end
        clear_inputs();
        check("starve_ack_cycle", ack_cyc, 6);
        check("starve_reg_data", bus.reg_data, TW'('h8));
        check("starve_batch_valid", bus.batch_valid, 1'b0);
        check("starve_wr_ptr", bus.wr_ptr, 4'd3);
        check("proto_lock_err", bus.lock_err, 1'b1);

        // Forced read of entry 5 while the pending write targets entry 5
        do_reset();
        for (int j = 0; j <= 16; j++) write(TW'('h200 + j));
        bus.reg_req  = 1'b1;
        bus.reg_addr = 4'd5;
        bus.wr_valid = 1'b1;
        bus.wr_tuple = TW'('h301);
        ack_cyc = 0;
        rdy5 = 1'b1;
        got_data = '0;
        ptr_at_ack = '0;
        for (int c = 1; c <= 12 && ack_cyc == 0; c++) begin
            logic granted;
            settle();
            granted = bus.wr_ready;
            if (c == 5) rdy5 = bus.wr_ready;
            tick();
            if (granted) bus.wr_tuple = bus.wr_tuple + TW'(1);
            if (bus.reg_ack) begin
                ack_cyc    = c + 1;
                got_data   = bus.reg_data;
                ptr_at_ack = bus.wr_ptr;
            end
        end
        bus.reg_req = 1'b0;
        check("rbw_forced_blocks_write", rdy5, 1'b0);
        check("rbw_ack_cycle", ack_cyc, 6);
        check("rbw_old_data", got_data, TW'('h205));
        check("rbw_ptr_at_ack", ptr_at_ack, 4'd5);
        tick();
        bus.wr_valid = 1'b0;
        check("rbw_ptr_after", bus.wr_ptr, 4'd6);
        reg_read("rbw_new_data", 4'd5, TW'('h305));
        reg_read("rbw_entry4", 4'd4, TW'('h304));

        // Lock abandoned after idx 0: released after 64 idle cycles
        do_reset();
        bus.batch_req = 1'b1;
        bus.batch_idx = 2'd0;
        tick();
        bus.batch_req = 1'b0;
        check("tmo_bvalid", bus.batch_valid, 1'b1);
        repeat (63) tick();
        bus.wr_valid = 1'b1;
        bus.wr_tuple = TW'('h77);
        settle();
        check("tmo_hold63_wr_ready", bus.wr_ready, 1'b0);
        check("tmo_hold63_lock_err", bus.lock_err, 1'b0);
        tick();
        check("tmo_lock_err", bus.lock_err, 1'b1);
        check("tmo_wr_ready", bus.wr_ready, 1'b1);
        tick();
        bus.wr_valid = 1'b0;
        check("tmo_wr_ptr", bus.wr_ptr, 4'd1);
        check("tmo_wr_count", bus.wr_count, 5'd1);

        // Reset while locked after idx 1, with another batch request pending
        do_reset();
        write(TW'('h99));
        bus.wr_valid  = 1'b0;
        bus.batch_req = 1'b1;
        bus.batch_idx = 2'd0;
        tick();
        bus.batch_idx = 2'd1;
        tick();
        check("abort_pre_bvalid", bus.batch_valid, 1'b1);
        check("abort_pre_wr_ready", bus.wr_ready, 1'b0);
        reset = 1'b1;
        bus.batch_idx = 2'd2;
        tick();
        reset = 1'b0;
        bus.batch_req = 1'b0;
        check("abort_bvalid", bus.batch_valid, 1'b0);
        check("abort_bdata", bus.batch_data, 512'd0);
        check("abort_reg_ack", bus.reg_ack, 1'b0);
        check("abort_reg_data", bus.reg_data, TW'(0));
        check("abort_wr_ptr", bus.wr_ptr, 4'd0);
        check("abort_wr_count", bus.wr_count, 5'd0);
        check("abort_lock_err", bus.lock_err, 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_tuple = TW'('h42);
        settle();
        check("abort_wr_ready", bus.wr_ready, 1'b1);
        tick();
        bus.wr_valid = 1'b0;
        reg_read("abort_mem0", 4'd0, TW'('h42));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
